ahb_lite_des_master: RTL

//  AHB-Lite initiator that drives one Triple DES job into the DES AHB-Lite slave.

---
 rtl/des_ahb_pkg.sv | 50 +++++
 rtl/ahb_lite_single_xfer.sv | 73 +++++++
 rtl/ahb_lite_des_master.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/des_ahb_pkg.sv
// Shared AHB-Lite encodings, DES slave register map and FSM state types
// for the Triple DES AHB-Lite initiator.
package des_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_64      = 3'b011;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DES     = 4'h3;

  localparam logic [7:0] OFF_DATA   = 8'h00;
  localparam logic [7:0] OFF_KEY1   = 8'h08;
  localparam logic [7:0] OFF_KEY2   = 8'h10;
  localparam logic [7:0] OFF_KEY3   = 8'h18;
  localparam logic [7:0] OFF_CTRL   = 8'h20;
  localparam logic [7:0] OFF_STATUS = 8'h28;
  localparam logic [7:0] OFF_RESULT = 8'h30;

  // Job steps: 0..3 data/keys, then CTRL, STATUS poll, RESULT read.
  localparam logic [2:0] STEP_CTRL   = 3'd4;
  localparam logic [2:0] STEP_STATUS = 3'd5;
  localparam logic [2:0] STEP_RESULT = 3'd6;

  typedef enum logic [2:0] {
    M_IDLE      = 3'd0,
    M_BUS       = 3'd1,
    M_POLL_WAIT = 3'd2,
    M_DONE      = 3'd3,
    M_ERR       = 3'd4
  } master_state_t;

  typedef enum logic [1:0] {
    X_IDLE = 2'd0,
    X_ADDR = 2'd1,
    X_DATA = 2'd2
  } xfer_state_t;

  function automatic logic [7:0] step_offset(input logic [2:0] step);
    case (step)
      3'd0:    return OFF_DATA;
      3'd1:    return OFF_KEY1;
      3'd2:    return OFF_KEY2;
      3'd3:    return OFF_KEY3;
      3'd4:    return OFF_CTRL;
      3'd5:    return OFF_STATUS;
      default: return OFF_RESULT;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lite_single_xfer.sv
// One non-overlapped AHB-Lite single transfer (ADDR then DATA phase).
// req is sampled when idle and again on the completing DATA cycle, so transfers chain back-to-back.
module ahb_lite_single_xfer
  import des_ahb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        write,
  input  logic [63:0] wdata,
  output logic        done,
  output logic        err,
  output logic [1:0]  dbg_state,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [1:0]  htrans,
  output logic [63:0] hwdata,
  input  logic        hready,
  input  logic        hresp
);

  xfer_state_t state;

  assign done      = (state == X_DATA) && hready && !hresp;
  assign err       = (state == X_DATA) && hresp;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= X_IDLE;
      htrans <= HTRANS_IDLE;
      haddr  <= '0;
      hwrite <= 1'b0;
      hwdata <= '0;
    end else begin
      case (state)
        X_IDLE: begin
          if (req) begin
            htrans <= HTRANS_NONSEQ;
            haddr  <= addr;
            hwrite <= write;
            state  <= X_ADDR;
          end
        end
        X_ADDR: begin
          if (hready) begin
            htrans <= HTRANS_IDLE;
            if (hwrite) hwdata <= wdata;
            state  <= X_DATA;
          end
        end
        X_DATA: begin
          // An error response aborts on its first cycle; the bus is already IDLE here.
          if (hresp) begin
            state <= X_IDLE;
          end else if (hready) begin
            if (req) begin
              htrans <= HTRANS_NONSEQ;
              haddr  <= addr;
              hwrite <= write;
              state  <= X_ADDR;
            end else begin
              state <= X_IDLE;
            end
          end
        end
        default: state <= X_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ahb_lite_des_master.sv
// AHB-Lite initiator running one Triple DES job on the DES slave: write DATA/KEY1-3/CTRL,
// poll STATUS, read RESULT. Optional poll timeout enabled by DES_MASTER_TIMEOUT_EN.
module ahb_lite_des_master
  import des_ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hAAAAAA00,
  parameter int          POLL_GAP  = 4
`ifdef DES_MASTER_TIMEOUT_EN
  , parameter int        TIMEOUT_POLLS = 1024
`endif
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key1,
  input  logic [63:0] in_key2,
  input  logic [63:0] in_key3,
  input  logic        in_encrypt,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [63:0] result_data,
  output logic        result_error,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [63:0] HWDATA,
  input  logic [63:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic [4:0]  dbg_state
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;

  master_state_t    state;
  logic [2:0]       step, step_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic [63:0]      job_data, job_key1, job_key2, job_key3;
  logic             job_enc;
  logic             req, xfer_done, xfer_err, write, poll_expired;
  logic [31:0]      addr;
  logic [63:0]      wdata;
  logic [1:0]       xfer_dbg;

  assign HSIZE       = HSIZE_64;
  assign HBURST      = HBURST_SINGLE;
  assign HPROT       = HPROT_DES;
  assign HMASTLOCK   = 1'b0;
  assign start_ready = (state == M_IDLE);
  assign dbg_state   = {xfer_dbg, state};

`ifdef DES_MASTER_TIMEOUT_EN
  localparam int PC_W = $clog2(TIMEOUT_POLLS + 1);
  logic [PC_W-1:0] poll_cnt;

  assign poll_expired = (int'(poll_cnt) >= TIMEOUT_POLLS - 1);

  // Consecutive not-done polls; saturates rather than wrapping.
  always_ff @(posedge HCLK) begin
    if (HRESET || state == M_IDLE) begin
      poll_cnt <= '0;
    end else if (state == M_BUS && xfer_done && step == STEP_STATUS) begin
      if (HRDATA[0])             poll_cnt <= '0;
      else if (poll_cnt != '1)   poll_cnt <= poll_cnt + 1'b1;
    end
  end
`else
  assign poll_expired = 1'b0;
`endif

  // The request for the next transfer is presented on the completing cycle so
  // the sub-module can chain it without an idle gap.
  always_comb begin
    req      = 1'b0;
    step_nxt = step;
    case (state)
      M_BUS: begin
        if (!xfer_done) begin
          req = 1'b1;
        end else if (step < STEP_STATUS) begin
          step_nxt = step + 3'd1;
          req      = 1'b1;
        end else if (step == STEP_STATUS) begin
          if (HRDATA[0]) begin
            step_nxt = STEP_RESULT;
            req      = 1'b1;
          end else if (POLL_GAP == 0 && !poll_expired) begin
            req = 1'b1;
          end
        end
      end
      M_POLL_WAIT: req = (gap_cnt == '0);
      default: ;
    endcase
  end

  always_comb begin
    addr  = BASE_ADDR + {24'd0, step_offset(step_nxt)};
    write = (step_nxt < STEP_STATUS);
    case (step_nxt)
      3'd0:      wdata = job_data;
      3'd1:      wdata = job_key1;
      3'd2:      wdata = job_key2;
      3'd3:      wdata = job_key3;
      STEP_CTRL: wdata = {62'd0, 1'b1, job_enc};
      default:   wdata = '0;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state        <= M_IDLE;
      step         <= '0;
      gap_cnt      <= '0;
      job_data     <= '0;
      job_key1     <= '0;
      job_key2     <= '0;
      job_key3     <= '0;
      job_enc      <= 1'b0;
      result_valid <= 1'b0;
      result_data  <= '0;
      result_error <= 1'b0;
    end else begin
      case (state)
        M_IDLE: begin
          if (start_valid) begin
            job_data <= in_data;
            job_key1 <= in_key1;
            job_key2 <= in_key2;
            job_key3 <= in_key3;
            job_enc  <= in_encrypt;
            step     <= '0;
            state    <= M_BUS;
          end
        end
        M_BUS: begin
          if (xfer_err) begin
            result_valid <= 1'b1;
            result_error <= 1'b1;
            result_data  <= '0;
            state        <= M_ERR;
          end else if (xfer_done) begin
            if (step == STEP_RESULT) begin
              result_valid <= 1'b1;
              result_error <= 1'b0;
              result_data  <= HRDATA;
              state        <= M_DONE;
            end else if (step == STEP_STATUS && !HRDATA[0]) begin
              if (poll_expired) begin
                result_valid <= 1'b1;
                result_error <= 1'b1;
                result_data  <= '0;
                state        <= M_ERR;
              end else if (POLL_GAP != 0) begin
                gap_cnt <= GAP_W'(POLL_GAP - 1);
                state   <= M_POLL_WAIT;
              end
            end else begin
              step <= step_nxt;
            end
          end
        end
        M_POLL_WAIT: begin
          if (gap_cnt == '0) state   <= M_BUS;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        M_DONE, M_ERR: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= M_IDLE;
          end
        end
        default: state <= M_IDLE;
      endcase
    end
  end

  ahb_lite_single_xfer u_xfer (
    .clk       (HCLK),
    .rst       (HRESET),
    .req       (req),
    .addr      (addr),
    .write     (write),
    .wdata     (wdata),
    .done      (xfer_done),
    .err       (xfer_err),
    .dbg_state (xfer_dbg),
    .haddr     (HADDR),
    .hwrite    (HWRITE),
    .htrans    (HTRANS),
    .hwdata    (HWDATA),
    .hready    (HREADY),
    .hresp     (HRESP)
  );

endmodule
